// File: rtl/lcd_blitter.sv
// Sprite blitter: pops 3-word commands, sets the LCD window, then streams RGB565 pixels
// fetched over AHB-Lite into the LCD write FIFO. Optional macro: LCD_BLITTER_COLORKEY_EN.
module lcd_blitter #(
    parameter int unsigned DIM_W     = 9,
    parameter logic [15:0] KEY_COLOR = 16'hF81F,
    parameter logic [15:0] BG_COLOR  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cmd_rdata,
    input  logic        cmd_rempty,
    output logic        cmd_rinc,
    input  logic        lcd_wfull,
    output logic        lcd_winc,
    output logic [16:0] lcd_wdata,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    output logic        init_mode,
    input  logic        init_done,
    output logic        busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_LD_XY, S_LD_SIZE, S_LD_ADDR, S_INIT, S_HDR, S_ADDR_PH, S_DATA_PH, S_PIX
    } state_t;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;

    state_t           state_q, state_d;
    logic [15:0]      x_q, x_d, y_q, y_d;
    logic [DIM_W-1:0] wm1_q, wm1_d, hm1_q, hm1_d;
    logic [DIM_W-1:0] col_q, col_d, row_q, row_d;
    logic [31:1]      addr_q, addr_d;
    logic [31:0]      buf_q, buf_d;
    logic [3:0]       hdr_idx_q, hdr_idx_d;
    logic             pend_q, pend_d;
    logic [16:0]      wdata_q, wdata_d;
    logic [1:0]       htrans_q, htrans_d;
    logic [31:0]      haddr_q, haddr_d;
    logic             init_mode_q, init_mode_d;

    logic        push_ok, slot_free, last_pix;
    logic [15:0] xe, ye, raw_pix, out_pix;
    logic [16:0] hdr_word;
    logic [31:1] addr_inc;

    // A word sits in wdata_q while pend_q is set; it leaves on any cycle the FIFO has room.
    assign push_ok   = pend_q & ~lcd_wfull;
    assign slot_free = ~pend_q | push_ok;
    assign last_pix  = (col_q == wm1_q) && (row_q == hm1_q);
    assign addr_inc  = addr_q + 31'd1;
    assign xe        = x_q + {{(16-DIM_W){1'b0}}, wm1_q};
    assign ye        = y_q + {{(16-DIM_W){1'b0}}, hm1_q};
    assign raw_pix   = addr_q[1] ? buf_q[31:16] : buf_q[15:0];

`ifdef LCD_BLITTER_COLORKEY_EN
    assign out_pix = (raw_pix == KEY_COLOR) ? BG_COLOR : raw_pix;
`else
    logic unused_colorkey;
    assign unused_colorkey = ^{KEY_COLOR, BG_COLOR};
    assign out_pix = raw_pix;
`endif

    always_comb begin
        case (hdr_idx_q)
            4'd0:    hdr_word = {1'b0, 16'h002A};
            4'd1:    hdr_word = {1'b1, 8'h00, x_q[15:8]};
            4'd2:    hdr_word = {1'b1, 8'h00, x_q[7:0]};
            4'd3:    hdr_word = {1'b1, 8'h00, xe[15:8]};
            4'd4:    hdr_word = {1'b1, 8'h00, xe[7:0]};
            4'd5:    hdr_word = {1'b0, 16'h002B};
            4'd6:    hdr_word = {1'b1, 8'h00, y_q[15:8]};
            4'd7:    hdr_word = {1'b1, 8'h00, y_q[7:0]};
            4'd8:    hdr_word = {1'b1, 8'h00, ye[15:8]};
            4'd9:    hdr_word = {1'b1, 8'h00, ye[7:0]};
            4'd10:   hdr_word = {1'b0, 16'h002C};
            default: hdr_word = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        wm1_d       = wm1_q;
        hm1_d       = hm1_q;
        col_d       = col_q;
        row_d       = row_q;
        addr_d      = addr_q;
        buf_d       = buf_q;
        hdr_idx_d   = hdr_idx_q;
        pend_d      = pend_q & ~push_ok;
        wdata_d     = wdata_q;
        htrans_d    = htrans_q;
        haddr_d     = haddr_q;
        init_mode_d = init_mode_q;

        case (state_q)
            S_IDLE: begin
                if (!cmd_rempty && !pend_q) state_d = S_LD_XY;
            end
            S_LD_XY: begin
                if (!cmd_rempty) begin
                    if (cmd_rdata == 32'hFFFF_FFFF) begin
                        state_d     = S_INIT;
                        init_mode_d = 1'b1;
                    end else begin
                        x_d     = cmd_rdata[31:16];
                        y_d     = cmd_rdata[15:0];
                        state_d = S_LD_SIZE;
                    end
                end
            end
            S_LD_SIZE: begin
                if (!cmd_rempty) begin
                    wm1_d   = cmd_rdata[16 +: DIM_W];
                    hm1_d   = cmd_rdata[0 +: DIM_W];
                    col_d   = '0;
                    row_d   = '0;
                    state_d = S_LD_ADDR;
                end
            end
            S_LD_ADDR: begin
                if (!cmd_rempty) begin
                    addr_d    = cmd_rdata[31:1];
                    hdr_idx_d = '0;
                    state_d   = S_HDR;
                end
            end
            S_INIT: begin
                if (init_done) begin
                    init_mode_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_HDR: begin
                if (hdr_idx_q == 4'd11) begin
                    state_d  = S_ADDR_PH;
                    htrans_d = HT_NONSEQ;
                    haddr_d  = {addr_q[31:2], 2'b00};
                end else if (slot_free) begin
                    wdata_d   = hdr_word;
                    pend_d    = 1'b1;
                    hdr_idx_d = hdr_idx_q + 4'd1;
                end
            end
            S_ADDR_PH: begin
                htrans_d = HT_IDLE;
                state_d  = S_DATA_PH;
            end
            S_DATA_PH: begin
                if (HREADY) begin
                    buf_d   = HRDATA;
                    state_d = S_PIX;
                end
            end
            S_PIX: begin
                if (slot_free) begin
                    wdata_d = {1'b1, out_pix};
                    pend_d  = 1'b1;
                    addr_d  = addr_inc;
                    if (col_q == wm1_q) begin
                        col_d = '0;
                        row_d = row_q + DIM_W'(1);
                    end else begin
                        col_d = col_q + DIM_W'(1);
                    end
                    // Upper half just consumed: the buffer is exhausted, refetch if more remain.
                    if (last_pix) begin
                        state_d = S_IDLE;
                    end else if (addr_q[1]) begin
                        state_d  = S_ADDR_PH;
                        htrans_d = HT_NONSEQ;
                        haddr_d  = {addr_inc[31:2], 2'b00};
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            wm1_q       <= '0;
            hm1_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            addr_q      <= '0;
            buf_q       <= '0;
            hdr_idx_q   <= '0;
            pend_q      <= 1'b0;
            wdata_q     <= '0;
            htrans_q    <= HT_IDLE;
            haddr_q     <= '0;
            init_mode_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            wm1_q       <= wm1_d;
            hm1_q       <= hm1_d;
            col_q       <= col_d;
            row_q       <= row_d;
            addr_q      <= addr_d;
            buf_q       <= buf_d;
            hdr_idx_q   <= hdr_idx_d;
            pend_q      <= pend_d;
            wdata_q     <= wdata_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            init_mode_q <= init_mode_d;
        end
    end

    assign cmd_rinc  = !cmd_rempty &&
                       (state_q == S_LD_XY || state_q == S_LD_SIZE || state_q == S_LD_ADDR);
    assign lcd_winc  = push_ok;
    assign lcd_wdata = wdata_q;
    assign HTRANS    = htrans_q;
    assign HADDR     = haddr_q;
    assign HSIZE     = 3'b010;
    assign HWRITE    = 1'b0;
    assign init_mode = init_mode_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_lcd_blitter.sv
// Scoreboard bench for lcd_blitter: expected LCD words and AHB fetch addresses are queued
// by the stimulus and checked by independent monitors.
module tb_lcd_blitter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] cmd_rdata = '0;
    logic        cmd_rempty = 1'b1;
    logic        cmd_rinc;
    logic        lcd_wfull = 1'b0;
    logic        lcd_winc;
    logic [16:0] lcd_wdata;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY = 1'b1;
    logic [31:0] HRDATA = '0;
    logic        init_mode;
    logic        init_done = 1'b0;
    logic        busy;

`ifdef LCD_BLITTER_COLORKEY_EN
    localparam logic [15:0] KEYED_PIX = 16'h0000;
`else
    localparam logic [15:0] KEYED_PIX = 16'hF81F;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] cmdq[$];
    logic [16:0] lcd_exp[$];
    logic [31:0] ahb_exp[$];
    logic [31:0] mem[logic [31:0]];
    int          hready_wait = 0;
    logic        toggle_full = 1'b0;
    logic        ignore = 1'b0;
    logic        pop_req = 1'b0;

    lcd_blitter #(.DIM_W(9), .KEY_COLOR(16'hF81F), .BG_COLOR(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_rdata(cmd_rdata), .cmd_rempty(cmd_rempty), .cmd_rinc(cmd_rinc),
        .lcd_wfull(lcd_wfull), .lcd_winc(lcd_winc), .lcd_wdata(lcd_wdata),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HREADY(HREADY), .HRDATA(HRDATA),
        .init_mode(init_mode), .init_done(init_done), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return ~a;
    endfunction

    task automatic refresh_cmd();
        cmd_rempty = (cmdq.size() == 0);
        cmd_rdata  = (cmdq.size() != 0) ? cmdq[0] : 32'h0;
    endtask

    task automatic push_cmd(input logic [31:0] w);
        cmdq.push_back(w);
        refresh_cmd();
    endtask

    // Command FIFO model: pop observed at negedge, applied just after the following edge.
    initial forever begin
        @(negedge clk);
        pop_req = cmd_rinc;
        if (cmd_rinc && cmd_rempty) chk("pop_while_empty", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        if (pop_req && cmdq.size() != 0) void'(cmdq.pop_front());
        refresh_cmd();
    end

    initial forever begin
        @(posedge clk);
        #1;
        lcd_wfull = toggle_full ? ~lcd_wfull : 1'b0;
    end

    // AHB slave: optional wait states, then data from the memory map.
    initial forever begin
        logic [31:0] a;
        @(posedge clk);
        if (rst_n && HTRANS == 2'b10 && HREADY) begin
            a = HADDR;
            #1;
            for (int i = 0; i < hready_wait; i++) begin
                HREADY = 1'b0;
                HRDATA = 32'hDEAD_BEEF;
                @(posedge clk);
                #1;
            end
            HREADY = 1'b1;
            HRDATA = mem_rd(a);
        end
    end

    // LCD monitor
    always @(negedge clk) begin
        if (rst_n && !ignore && lcd_winc) begin
            chk("winc_while_full", {31'd0, lcd_wfull}, 32'd0);
            if (lcd_exp.size() == 0) begin
                chk("lcd_unexpected_push", {15'd0, lcd_wdata}, 32'hFFFF_FFFF);
            end else begin
                chk("lcd_word", {15'd0, lcd_wdata}, {15'd0, lcd_exp.pop_front()});
            end
        end
    end

    // AHB monitor
    always @(negedge clk) begin
        if (rst_n && !ignore) begin
            if (HTRANS == 2'b10) begin
                if (ahb_exp.size() == 0) chk("ahb_unexpected_fetch", HADDR, 32'hFFFF_FFFF);
                else chk("ahb_addr", HADDR, ahb_exp.pop_front());
                chk("ahb_hsize", {29'd0, HSIZE}, 32'd2);
                chk("ahb_hwrite", {31'd0, HWRITE}, 32'd0);
            end
            if (!HREADY) chk("htrans_during_wait", {30'd0, HTRANS}, 32'd0);
        end
    end

    task automatic exp_header(input logic [31:0] w0, input logic [15:0] xe, input logic [15:0] ye);
        lcd_exp.push_back({1'b0, 16'h002A});
        lcd_exp.push_back({1'b1, 8'h00, w0[31:24]});
        lcd_exp.push_back({1'b1, 8'h00, w0[23:16]});
        lcd_exp.push_back({1'b1, 8'h00, xe[15:8]});
        lcd_exp.push_back({1'b1, 8'h00, xe[7:0]});
        lcd_exp.push_back({1'b0, 16'h002B});
        lcd_exp.push_back({1'b1, 8'h00, w0[15:8]});
        lcd_exp.push_back({1'b1, 8'h00, w0[7:0]});
        lcd_exp.push_back({1'b1, 8'h00, ye[15:8]});
        lcd_exp.push_back({1'b1, 8'h00, ye[7:0]});
        lcd_exp.push_back({1'b0, 16'h002C});
    endtask

    task automatic exp_pix(input logic [15:0] p);
        lcd_exp.push_back({1'b1, p});
    endtask

    task automatic send_sprite(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        push_cmd(w0);
        push_cmd(w1);
        push_cmd(w2);
    endtask

    task automatic wait_idle(input string name);
        int cyc = 0;
        while ((lcd_exp.size() != 0 || ahb_exp.size() != 0 || cmdq.size() != 0 || busy) && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({name, "_done_in_time"}, {31'd0, cyc >= 2000}, 32'd0);
        chk({name, "_lcd_left"}, lcd_exp.size(), 32'd0);
        chk({name, "_ahb_left"}, ahb_exp.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_cmd_rinc"}, {31'd0, cmd_rinc}, 32'd0);
        chk({name, "_lcd_winc"}, {31'd0, lcd_winc}, 32'd0);
        chk({name, "_lcd_wdata"}, {15'd0, lcd_wdata}, 32'd0);
        chk({name, "_htrans"}, {30'd0, HTRANS}, 32'd0);
        chk({name, "_haddr"}, HADDR, 32'd0);
        chk({name, "_hsize"}, {29'd0, HSIZE}, 32'd2);
        chk({name, "_hwrite"}, {31'd0, HWRITE}, 32'd0);
        chk({name, "_init_mode"}, {31'd0, init_mode}, 32'd0);
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int viol;
        mem[32'h100] = 32'hBBBB_AAAA;
        mem[32'h104] = 32'hDDDD_CCCC;
        mem[32'h200] = 32'h6666_5555;
        mem[32'h204] = 32'h8888_7777;
        mem[32'h300] = 32'h1234_F81F;
        mem[32'h400] = 32'h1234_F81F;
        mem[32'h600] = 32'h2222_1111;
        mem[32'h604] = 32'h4444_3333;

        #3 rst_n = 1'b0;
        #20;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 2x2 sprite, word-aligned
        exp_header(32'h0010_0020, 16'h0011, 16'h0021);
        exp_pix(16'hAAAA); exp_pix(16'hBBBB); exp_pix(16'hCCCC); exp_pix(16'hDDDD);
        ahb_exp.push_back(32'h100); ahb_exp.push_back(32'h104);
        send_sprite(32'h0010_0020, 32'h0001_0001, 32'h0000_0100);
        wait_idle("sprite_2x2");

        // 1x3 sprite from odd halfword, 5 wait states per fetch
        hready_wait = 5;
        exp_header(32'h0005_0007, 16'h0005, 16'h0009);
        exp_pix(16'h2222); exp_pix(16'h3333); exp_pix(16'h4444);
        ahb_exp.push_back(32'h600); ahb_exp.push_back(32'h604);
        send_sprite(32'h0005_0007, 32'h0000_0002, 32'h0000_0602);
        wait_idle("sprite_odd_wait");
        hready_wait = 0;

        // 4x1 sprite with X end wrapping, FIFO full every other cycle
        toggle_full = 1'b1;
        exp_header(32'hFFFE_0001, 16'h0001, 16'h0001);
        exp_pix(16'h5555); exp_pix(16'h6666); exp_pix(16'h7777); exp_pix(16'h8888);
        ahb_exp.push_back(32'h200); ahb_exp.push_back(32'h204);
        send_sprite(32'hFFFE_0001, 32'h0003_0000, 32'h0000_0200);
        wait_idle("sprite_backpressure");
        toggle_full = 1'b0;

        // Init request, then a 1x1 sprite behind it
        push_cmd(32'hFFFF_FFFF);
        exp_header(32'h0003_0004, 16'h0003, 16'h0004);
        exp_pix(KEYED_PIX);
        ahb_exp.push_back(32'h300);
        send_sprite(32'h0003_0004, 32'h0000_0000, 32'h0000_0300);
        repeat (12) @(posedge clk);
        #1;
        chk("init_mode_high", {31'd0, init_mode}, 32'd1);
        chk("init_no_pop", cmdq.size(), 32'd3);
        chk("init_busy", {31'd0, busy}, 32'd1);
        init_done = 1'b1;
        @(posedge clk);
        #1;
        init_done = 1'b0;
        chk("init_mode_low", {31'd0, init_mode}, 32'd0);
        wait_idle("init_then_1x1");

        // Colour key: 2x1 sprite over 0x1234_F81F
        exp_header(32'h0000_0000, 16'h0001, 16'h0000);
        exp_pix(KEYED_PIX); exp_pix(16'h1234);
        ahb_exp.push_back(32'h400);
        send_sprite(32'h0000_0000, 32'h0001_0000, 32'h0000_0400);
        wait_idle("colorkey");

        // Reset in the middle of a 4x4 sprite
        send_sprite(32'h0000_0000, 32'h0003_0003, 32'h0000_0500);
        ignore = 1'b1;
        repeat (22) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        lcd_exp.delete();
        ahb_exp.delete();
        check_reset_outputs("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lcd_winc || HTRANS != 2'b00 || busy) viol++;
        end
        chk("post_reset_quiet", viol, 32'd0);
        ignore = 1'b0;

        // Recovery after reset
        @(posedge clk);
        #1;
        exp_header(32'h0010_0020, 16'h0011, 16'h0021);
        exp_pix(16'hAAAA); exp_pix(16'hBBBB); exp_pix(16'hCCCC); exp_pix(16'hDDDD);
        ahb_exp.push_back(32'h100); ahb_exp.push_back(32'h104);
        send_sprite(32'h0010_0020, 32'h0001_0001, 32'h0000_0100);
        wait_idle("after_reset");

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
